// File: rtl/y_demux_buf_if.sv
// y_demux_buf_if -- handshake bundle for the 1-to-2 demultiplexing buffer.
//   in_data/in_sel/in_valid -> upstream word, destination and strobe
//   in_ready                <- the selected channel has room
//   outN_data/outN_valid    <- head word of channel N (zeros when empty)
//   outN_ready              -> channel N consumer takes the head word
//   cnt0/cnt1               <- words popped per channel, modulo 2^16
// master: the producer/consumer side; slave: the buffer itself.
interface y_demux_buf_if #(
    parameter int SIZE = 32
);
    logic [SIZE-1:0] in_data;
    logic            in_sel;
    logic            in_valid;
    logic            in_ready;
    logic [SIZE-1:0] out0_data;
    logic            out0_valid;
    logic            out0_ready;
    logic [SIZE-1:0] out1_data;
    logic            out1_valid;
    logic            out1_ready;
    logic [15:0]     cnt0;
    logic [15:0]     cnt1;

    modport master (
        output in_data, in_sel, in_valid, out0_ready, out1_ready,
        input  in_ready, out0_data, out0_valid, out1_data, out1_valid, cnt0, cnt1
    );

    modport slave (
        input  in_data, in_sel, in_valid, out0_ready, out1_ready,
        output in_ready, out0_data, out0_valid, out1_data, out1_valid, cnt0, cnt1
    );
endinterface

// File: rtl/y_demux_buf.sv
// y_demux_buf -- routes each input word to one of two independent FIFO
// channels chosen by in_sel, and counts the words popped from each channel.
//   clk : single clock, rising edge
//   rst : asynchronous, active-high reset; empties both channels and
//         clears the pop counters
//   bus : y_demux_buf_if.slave (input word + select, two output channels,
//         two pop counters)
// There is no combinational path from the input side to the outputs: a word
// becomes visible on its channel the cycle after the push edge.

// One output channel: a DEPTH-entry FIFO plus its pop counter.
//   push/push_data : write one word (caller guarantees !full)
//   pop_rdy        : consumer ready; a pop happens only when out_valid
//   full           : DEPTH words held
//   out_data       : head word, forced to zero while empty
//   out_valid      : channel non-empty
//   cnt            : pops, modulo 2^16
module y_demux_buf_chan #(
    parameter int SIZE  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic [SIZE-1:0] push_data,
    input  logic            pop_rdy,
    output logic            full,
    output logic [SIZE-1:0] out_data,
    output logic            out_valid,
    output logic [15:0]     cnt
);
    localparam int AW = $clog2(DEPTH);
    // Occupancy is one bit wider than the pointers so full and empty are
    // distinct even though the pointers are equal in both cases.
    localparam logic [AW:0] FULL_OCC = DEPTH[AW:0];

    logic [DEPTH-1:0][SIZE-1:0] mem;
    logic [AW-1:0]              wptr;
    logic [AW-1:0]              rptr;
    logic [AW:0]                occ;
    logic                       pop;

    assign out_valid = (occ != '0);
    assign full      = (occ == FULL_OCC);
    assign pop       = out_valid && pop_rdy;
    // Storage is not reset; masking with out_valid keeps stale entries hidden.
    assign out_data  = out_valid ? mem[rptr] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            occ  <= '0;
            cnt  <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop) begin
                rptr <= rptr + 1'b1;
                cnt  <= cnt + 16'd1;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= push_data;
    end
endmodule

module y_demux_buf #(
    parameter int SIZE  = 32,
    parameter int DEPTH = 2
) (
    input logic          clk,
    input logic          rst,
    y_demux_buf_if.slave bus
);
    localparam int NUM_CH = 2;

    typedef struct packed {
        logic            sel;
        logic [SIZE-1:0] data;
    } req_t;

    req_t                          req;
    logic                          in_ready;
    logic [NUM_CH-1:0]             ch_push;
    logic [NUM_CH-1:0]             ch_pop_rdy;
    logic [NUM_CH-1:0]             ch_full;
    logic [NUM_CH-1:0]             ch_valid;
    logic [NUM_CH-1:0][SIZE-1:0]   ch_data;
    logic [NUM_CH-1:0][15:0]       ch_cnt;

    assign req        = '{sel: bus.in_sel, data: bus.in_data};
    assign ch_pop_rdy = {bus.out1_ready, bus.out0_ready};

    // Ready looks only at the selected channel's fill level, so a pop on a
    // full channel in the same cycle never lets a push through.
    always_comb begin
        ch_push  = '0;
        in_ready = !ch_full[req.sel];
        if (bus.in_valid && in_ready) ch_push[req.sel] = 1'b1;
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        y_demux_buf_chan #(
            .SIZE  (SIZE),
            .DEPTH (DEPTH)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .push      (ch_push[g]),
            .push_data (req.data),
            .pop_rdy   (ch_pop_rdy[g]),
            .full      (ch_full[g]),
            .out_data  (ch_data[g]),
            .out_valid (ch_valid[g]),
            .cnt       (ch_cnt[g])
        );
    end

    assign bus.in_ready   = in_ready;
    assign bus.out0_data  = ch_data[0];
    assign bus.out0_valid = ch_valid[0];
    assign bus.out1_data  = ch_data[1];
    assign bus.out1_valid = ch_valid[1];
    assign bus.cnt0       = ch_cnt[0];
    assign bus.cnt1       = ch_cnt[1];
endmodule

// File: tb/tb_y_demux_buf.sv
module tb_y_demux_buf;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    y_demux_buf_if #(.SIZE(32)) bus();

    y_demux_buf #(.SIZE(32), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: one queue of expected words per channel plus pop counts.
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [15:0] m_cnt0 = 16'd0;
    logic [15:0] m_cnt1 = 16'd0;
    int          pops = 0;
    int          occ_pre0 = 0;
    int          occ_pre1 = 0;
    int          n_vec = 0;
    int          n_fail = 0;
    bit          release_req = 1'b0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Monitor: compares the DUT outputs with the model every cycle and
    // retires the words that the coming edge pops.
    always @(negedge clk) begin
        chk("out0_valid", 32'(bus.out0_valid), 32'(q0.size() != 0));
        chk("out0_data",  bus.out0_data, (q0.size() != 0) ? q0[0] : 32'd0);
        chk("cnt0",       32'(bus.cnt0), 32'(m_cnt0));
        chk("out1_valid", 32'(bus.out1_valid), 32'(q1.size() != 0));
        chk("out1_data",  bus.out1_data, (q1.size() != 0) ? q1[0] : 32'd0);
        chk("cnt1",       32'(bus.cnt1), 32'(m_cnt1));
        occ_pre0 = q0.size();
        occ_pre1 = q1.size();
        chk("in_ready", 32'(bus.in_ready), 32'((bus.in_sel ? occ_pre1 : occ_pre0) < DEPTH));
        if (!rst) begin
            if (bus.out0_ready && q0.size() != 0) begin
                void'(q0.pop_front());
                m_cnt0 = m_cnt0 + 16'd1;
                pops++;
            end
            if (bus.out1_ready && q1.size() != 0) begin
                void'(q1.pop_front());
                m_cnt1 = m_cnt1 + 16'd1;
                pops++;
            end
        end
    end

    // One clock cycle of stimulus; the expected word is queued when the model
    // says the selected channel had room before this edge.
    task automatic cycle(input bit v, input bit s, input logic [31:0] d,
                         input bit r0, input bit r1, output bit acc);
        @(posedge clk);
        #1;
        bus.in_valid   = v;
        bus.in_sel     = s;
        bus.in_data    = d;
        bus.out0_ready = r0;
        bus.out1_ready = r1;
        if (release_req) begin
            #1;
            rst = 1'b0;
            release_req = 1'b0;
        end
        @(negedge clk);
        #1;
        acc = v && !rst && ((s ? occ_pre1 : occ_pre0) < DEPTH);
        if (acc) begin
            if (s) q1.push_back(d);
            else   q0.push_back(d);
        end
    endtask

    task automatic rst_mid();
        @(posedge clk);
        #3;
        rst = 1'b1;
        q0.delete();
        q1.delete();
        m_cnt0 = 16'd0;
        m_cnt1 = 16'd0;
        pops = 0;
        #1;
        chk("rst_out0_valid", 32'(bus.out0_valid), 32'd0);
        chk("rst_out1_valid", 32'(bus.out1_valid), 32'd0);
        chk("rst_out0_data",  bus.out0_data, 32'd0);
        chk("rst_out1_data",  bus.out1_data, 32'd0);
        chk("rst_cnt0",       32'(bus.cnt0), 32'd0);
        chk("rst_cnt1",       32'(bus.cnt1), 32'd0);
    endtask

    initial begin
        bit acc;
        int n;
        bus.in_valid   = 1'b0;
        bus.in_sel     = 1'b0;
        bus.in_data    = 32'd0;
        bus.out0_ready = 1'b0;
        bus.out1_ready = 1'b0;

        // Pushes and pops during reset must not take effect.
        cycle(1, 0, 32'h1111_1111, 1, 1, acc);
        cycle(1, 1, 32'h2222_2222, 1, 1, acc);

        // First edge after release accepts the push; visible one cycle later.
        release_req = 1'b1;
        cycle(1, 0, 32'hAAAA_5555, 0, 0, acc);
        cycle(0, 0, 32'd0, 0, 0, acc);
        cycle(0, 0, 32'd0, 1, 0, acc);

        // Channel 1 fills at two words; a third push is refused.
        cycle(1, 1, 32'h1, 0, 0, acc);
        cycle(1, 1, 32'h2, 0, 0, acc);
        cycle(1, 1, 32'h3, 0, 0, acc);
        cycle(1, 0, 32'h0, 0, 0, acc);
        cycle(0, 1, 32'h0, 0, 1, acc);
        cycle(0, 1, 32'h0, 0, 1, acc);
        cycle(0, 0, 32'h0, 1, 0, acc);
        cycle(0, 0, 32'h0, 0, 0, acc);
        chk("cnt1_after_two_pops", 32'(bus.cnt1), 32'd2);

        // Full channel 0 with a simultaneous pop: pop only, no push-through.
        cycle(1, 0, 32'hA0, 0, 0, acc);
        cycle(1, 0, 32'hB0, 0, 0, acc);
        cycle(1, 0, 32'hC0, 1, 0, acc);
        cycle(0, 0, 32'h0, 0, 0, acc);
        cycle(0, 0, 32'h0, 1, 0, acc);

        // Reset between edges with both channels non-empty.
        cycle(1, 0, 32'hDEAD_0000, 0, 0, acc);
        cycle(1, 1, 32'hDEAD_0001, 0, 0, acc);
        rst_mid();
        cycle(1, 0, 32'hBAD0_0000, 1, 1, acc);
        release_req = 1'b1;
        cycle(1, 1, 32'h600D_0001, 0, 0, acc);
        cycle(1, 0, 32'h600D_0000, 0, 1, acc);
        cycle(0, 0, 32'h0, 1, 1, acc);
        cycle(0, 0, 32'h0, 0, 0, acc);

        // Random traffic: 500 words, each held until the model accepts it.
        for (int w = 0; w < 500; w++) begin
            logic [31:0] d;
            bit          s;
            d = $urandom;
            s = 1'($urandom_range(0, 1));
            acc = 1'b0;
            n = 0;
            while (!acc && n < 100) begin
                cycle(1, s, d, ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7), acc);
                n++;
            end
            if (!acc) chk("random_push_timeout", 32'd0, 32'd1);
        end
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 50) begin
            cycle(0, 0, 32'h0, 1, 1, acc);
            n++;
        end
        cycle(0, 0, 32'h0, 0, 0, acc);
        chk("drain_out0_valid", 32'(bus.out0_valid), 32'd0);
        chk("drain_out1_valid", 32'(bus.out1_valid), 32'd0);
        chk("pop_total", 32'(bus.cnt0) + 32'(bus.cnt1), 32'(pops));

        // Counter wrap: 65537 pops on channel 0.
        rst_mid();
        release_req = 1'b1;
        cycle(0, 0, 32'h0, 0, 0, acc);
        n = 0;
        while (pops < 65537 && n < 70000) begin
            cycle(1, 0, $urandom, 1, 0, acc);
            n++;
        end
        cycle(0, 0, 32'h0, 0, 0, acc);
        chk("cnt0_wrap", 32'(bus.cnt0), 32'h0000_0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/y_demux_buf.md
Y_DEMUX_BUF -- requirements
Module: y_demux_buf

Interface
REQ-001 Parameter SIZE, default 32: data width in bits of the input and both output channels.
REQ-002 Parameter DEPTH, default 2: entries per output-channel FIFO; power of two, at least 2.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_data  input  SIZE  word to be routed.
REQ-006 in_sel  input  1  destination select: 0 routes to channel 0, 1 routes to channel 1.
REQ-007 in_valid  input  1  in_data/in_sel valid this cycle.
REQ-008 in_ready  output  1  block accepts the presented word this cycle.
REQ-009 out0_data  output  SIZE  head word of channel 0.
REQ-010 out0_valid  output  1  channel 0 FIFO non-empty.
REQ-011 out0_ready  input  1  channel 0 consumer takes head word.
REQ-012 out1_data, out1_valid, out1_ready: same as REQ-009..011, for channel 1.
REQ-013 cnt0  output  16  words popped from channel 0, modulo 2^16.
REQ-014 cnt1  output  16  words popped from channel 1, modulo 2^16.

Function
REQ-015 Push to channel N: in_valid=1, in_ready=1 and in_sel=N at a rising edge.
REQ-016 in_ready = (channel in_sel holds fewer than DEPTH words); combinational in in_sel and FIFO state; independent of in_valid and of both outN_ready.
REQ-017 Full channel: no push-through bypass; in_ready=0 even if that channel pops in the same cycle.
REQ-018 Non-selected channel: never written; its state changes only by its own pop.
REQ-019 Pop of channel N: outN_valid=1 and outN_ready=1 at a rising edge.
REQ-020 outN_ready while outN_valid=0: ignored, no state change.
REQ-021 Latency: word pushed into an empty channel appears on outN_data with outN_valid=1 the cycle after the push edge; no combinational in-to-out path.
REQ-022 Ordering: FIFO order per channel; no ordering guarantee between channels.
REQ-023 Simultaneous push and pop on the same non-full channel: occupancy unchanged; pushed word queued behind existing words.
REQ-024 Simultaneous pops on both channels in one cycle: both legal and independent.
REQ-025 Read/write pointers per channel wrap modulo DEPTH; occupancy range 0..DEPTH, tracked without ambiguity at full.
REQ-026 outN_data = storage[read pointer] when outN_valid=1; all zeros when outN_valid=0.
REQ-027 cntN increments by 1 on each pop of channel N; wraps 0xFFFF -> 0x0000.
REQ-028 Values on in_data/in_sel when in_valid=0 or in_ready=0: no effect.

Reset
REQ-029 rst=1 immediately, without waiting for clk, forces: all pointers and occupancies to 0, out0_valid=out1_valid=0, out0_data=out1_data=0, cnt0=cnt1=0.
REQ-030 While rst=1: in_ready=1 for both in_sel values (channels empty); no push or pop takes effect.
REQ-031 Reset mid-operation: all queued words discarded; none reappear after rst falls.
REQ-032 First push is accepted at the first rising edge with rst=0.

Verification
REQ-033 Reset, then push 0xAAAA5555 with sel=0, out0_ready=0 -> next cycle out0_valid=1, out0_data=0xAAAA5555; out1_valid=0, out1_data=0.
REQ-034 Push 0x1, 0x2 to channel 1 with out1_ready=0 -> in_ready=0 when in_sel=1 and 1 when in_sel=0; a third push with sel=1 is not accepted; popping yields 0x1 then 0x2; cnt1=2.
REQ-035 Channel 0 full, in_sel=0, in_valid=1, out0_ready=1 in the same cycle -> one pop only, no push; occupancy 1 after the edge.
REQ-036 Random traffic (500 words, random sel, random ready on both outputs) against a reference model -> per-channel order and data match, no loss or duplication, and cnt0+cnt1 equals total pops.
REQ-037 Hold out0_ready=1 with continuous sel=0 pushes for 65537 pops -> cnt0 wraps to 0x0001.
REQ-038 Assert rst between edges with both channels non-empty -> valids, data, and counters are 0 before the next edge; after release, first pops return only newly pushed words.
